brg_hcc_req_gate: RTL and testbench
===================================

Name: brg_hcc_req_gate

Overview:
Sits between the BrgHBTile request/response ports and bsg_manycore_endpoint_standard in an HCC tile. On the request path it buffers outgoing packets in a 2-entry FIFO and holds back a credit reserve. It also keeps a per-register scoreboard of outstanding remote loads and stalls a second load to a register that is still pending (WAW hazard). The response path passes through, and load write-backs clear scoreboard bits.

Parameters:
packet_width_lp, 1, width of an opaque manycore request packet; the instantiating tile passes its computed value.
data_width_p, 32, returned data width.
max_out_credits_p, 200, endpoint credit capacity.
credit_reserve_p, 0, credits held back; issue requires ep_credits_i > credit_reserve_p.
load_ret_type_p, 2'b00, returned pkt_type value meaning load write-back.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
tile_v_i  in  1  tile request valid
tile_packet_i  in  packet_width_lp  request packet
tile_is_load_i  in  1  request is a remote load
tile_reg_id_i  in  5  load destination register
tile_ready_o  out  1  request accepted when tile_v_i & tile_ready_o
ep_v_o  out  1  packet valid to endpoint
ep_packet_o  out  packet_width_lp  packet to endpoint
ep_credit_or_ready_i  in  1  endpoint ready
ep_credits_i  in  $clog2(max_out_credits_p+1)  endpoint free credits
ep_returned_v_r_i  in  1  response valid
ep_returned_data_r_i  in  data_width_p  response data
ep_returned_reg_id_r_i  in  5  response register id
ep_returned_pkt_type_r_i  in  2  response type
ep_returned_yumi_o  out  1  response consumed
tile_returned_v_o / tile_returned_data_o / tile_returned_reg_id_o / tile_returned_pkt_type_o  out  1/data_width_p/5/2  response to tile
tile_returned_yumi_i  in  1  tile consumes response

Behaviour:
- Reset (async assert, sync deassert): FIFO empty, scoreboard cleared to 32'b0, ep_v_o=0. Any buffered packets are dropped. A reset asserted mid-operation discards all state immediately.
- hazard = tile_is_load_i & (tile_reg_id_i != 0) & sb_r[tile_reg_id_i]. It uses registered sb_r only.
- tile_ready_o = ~fifo_full & ~hazard. It depends combinationally on tile inputs, with no loop back to tile_v_i. Out of reset with an empty FIFO, tile_ready_o=1 unless hazard is asserted.
- Enqueue on tile_v_i & tile_ready_o. The packet is written at the tail.
- Set bit: if the enqueued request is a load with reg_id != 0, set sb_r[reg_id] next cycle. Loads to x0 never set the scoreboard.
- ep_v_o = ~fifo_empty & (ep_credits_i > credit_reserve_p). ep_packet_o = head entry.
- Dequeue on ep_v_o & ep_credit_or_ready_i.
- FIFO latency: minimum 1 cycle from accept to ep_v_o, because the FIFO is not bypassed. The FIFO sustains 1 packet/cycle when the endpoint is always ready and credits are available.
- Simultaneous enqueue and dequeue on a full FIFO: enqueue is not allowed, since ready is low when full.
- Simultaneous enqueue and dequeue with 1 entry: occupancy stays at 1.
- Response path is combinational pass-through: tile_returned_* = ep_returned_*, and ep_returned_yumi_o = tile_returned_yumi_i.
- Clear bit on tile_returned_yumi_i & ep_returned_v_r_i & (pkt_type == load_ret_type_p): sb_r[reg_id] is cleared next cycle.
- A load to the same reg_id presented in the clear cycle still stalls that cycle and is accepted the next cycle.
- Set and clear of different bits in the same cycle both take effect.
- A set and clear of the same bit cannot coincide, because the hazard blocks the set.
- Non-load responses never modify the scoreboard.

Optional Feature:
Macro: BRG_HCC_REQ_GATE_STATS_EN.
- When defined, adds outputs stall_hazard_cnt_o[31:0] and stall_credit_cnt_o[31:0]. Both reset to 0 and saturate at 32'hFFFF_FFFF.
- stall_hazard_cnt_o increments each cycle in which tile_v_i & hazard.
- stall_credit_cnt_o increments each cycle in which ~fifo_empty & (ep_credits_i <= credit_reserve_p).
- When undefined, the ports and counters are absent and the block's function is otherwise identical.

Test Plan:
- Credits 200, ep ready=1, two back-to-back stores A,B → ep_v_o carries A on cycle 1 and B on cycle 2, tile_ready_o stays 1, and the scoreboard stays 0.
- Hold ep_credit_or_ready_i=0 and send 3 stores → first 2 accepted, tile_ready_o=0 on the 3rd, ep_v_o=1 with the first packet stable; release ready → packets delivered in order A,B,C.
- Load to r5, then a second load to r5 → second load stalls (tile_ready_o=0). Return pkt_type 0, reg 5, with yumi → second load accepted the cycle after the clear.
- Load to r0 twice back-to-back → both accepted with no stall and sb_r stays 0.
- credit_reserve_p=2 with ep_credits_i=2 and the FIFO non-empty → ep_v_o=0. Raise ep_credits_i to 3 → ep_v_o=1 the same cycle.
- Load r7 pending with 2 packets queued, then pulse reset_n_i low → ep_v_o=0 immediately, FIFO empty, sb_r=0; after reset a load to r7 is accepted without stall.

Source files
------------

// File: rtl/brg_hcc_req_gate.sv
// brg_hcc_req_gate
// Request-side gate between the HCC tile and the manycore endpoint.
// - Outgoing requests pass through a 2-entry FIFO. The FIFO is never bypassed.
// - A packet is offered to the endpoint only while free credits exceed a reserve.
// - A 32-bit scoreboard tracks outstanding remote loads, one bit per register.
//   A second load to a register that is still pending is held off.
// - The response path passes straight through to the tile. Load write-backs
//   clear the matching scoreboard bit.
// Optional feature: define BRG_HCC_REQ_GATE_STATS_EN to add saturating stall
// counters (stall_hazard_cnt_o, stall_credit_cnt_o).

module brg_hcc_req_gate #(
  parameter int         packet_width_lp   = 1,
  parameter int         data_width_p      = 32,
  parameter int         max_out_credits_p = 200,
  parameter int         credit_reserve_p  = 0,
  parameter logic [1:0] load_ret_type_p   = 2'b00
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,

  input  logic                                     tile_v_i,
  input  logic [packet_width_lp-1:0]               tile_packet_i,
  input  logic                                     tile_is_load_i,
  input  logic [4:0]                               tile_reg_id_i,
  output logic                                     tile_ready_o,

  output logic                                     ep_v_o,
  output logic [packet_width_lp-1:0]               ep_packet_o,
  input  logic                                     ep_credit_or_ready_i,
  input  logic [$clog2(max_out_credits_p+1)-1:0]   ep_credits_i,

  input  logic                                     ep_returned_v_r_i,
  input  logic [data_width_p-1:0]                  ep_returned_data_r_i,
  input  logic [4:0]                               ep_returned_reg_id_r_i,
  input  logic [1:0]                               ep_returned_pkt_type_r_i,
  output logic                                     ep_returned_yumi_o,

  output logic                                     tile_returned_v_o,
  output logic [data_width_p-1:0]                  tile_returned_data_o,
  output logic [4:0]                               tile_returned_reg_id_o,
  output logic [1:0]                               tile_returned_pkt_type_o,
  input  logic                                     tile_returned_yumi_i
`ifdef BRG_HCC_REQ_GATE_STATS_EN
  ,
  output logic [31:0]                              stall_hazard_cnt_o,
  output logic [31:0]                              stall_credit_cnt_o
`endif
);

  localparam int                       credit_width_lp = $clog2(max_out_credits_p+1);
  localparam logic [credit_width_lp-1:0] reserve_lp    = credit_width_lp'(credit_reserve_p);

  // FIFO storage and control
  logic [packet_width_lp-1:0] mem_r [2];
  logic                       wr_ptr_r;
  logic                       rd_ptr_r;
  logic [1:0]                 count_r;
  logic [1:0]                 count_next_s;

  logic fifo_full_s;
  logic fifo_empty_s;
  logic credit_ok_s;
  logic hazard_s;
  logic enq_s;
  logic deq_s;

  // Scoreboard of outstanding loads
  logic [31:0] sb_r;
  logic [31:0] sb_set_s;
  logic [31:0] sb_clr_s;
  logic [31:0] sb_next_s;
  logic        ret_load_s;

  // Request-side handshakes. The hazard looks only at the registered scoreboard,
  // so a clear arriving this cycle still stalls a matching load until the next one.
  always_comb begin
    fifo_full_s  = (count_r == 2'd2);
    fifo_empty_s = (count_r == 2'd0);
    credit_ok_s  = (ep_credits_i > reserve_lp);
    hazard_s     = tile_is_load_i & (tile_reg_id_i != 5'd0) & sb_r[tile_reg_id_i];
    tile_ready_o = ~fifo_full_s & ~hazard_s;
    enq_s        = tile_v_i & tile_ready_o;
    ep_v_o       = ~fifo_empty_s & credit_ok_s;
    ep_packet_o  = mem_r[rd_ptr_r];
    deq_s        = ep_v_o & ep_credit_or_ready_i;
  end

  // FIFO occupancy update for every enqueue/dequeue combination
  always_comb begin
    count_next_s = count_r;
    case ({enq_s, deq_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and storage
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else begin
      count_r <= count_next_s;
      if (enq_s) begin
        mem_r[wr_ptr_r] <= tile_packet_i;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (deq_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Response path is a straight wire-through in both directions
  always_comb begin
    tile_returned_v_o        = ep_returned_v_r_i;
    tile_returned_data_o     = ep_returned_data_r_i;
    tile_returned_reg_id_o   = ep_returned_reg_id_r_i;
    tile_returned_pkt_type_o = ep_returned_pkt_type_r_i;
    ep_returned_yumi_o       = tile_returned_yumi_i;
  end

  // Scoreboard set/clear masks. Register x0 is never tracked.
  always_comb begin
    sb_set_s   = 32'd0;
    sb_clr_s   = 32'd0;
    ret_load_s = tile_returned_yumi_i & ep_returned_v_r_i &
                 (ep_returned_pkt_type_r_i == load_ret_type_p);
    if (enq_s && tile_is_load_i && (tile_reg_id_i != 5'd0)) begin
      sb_set_s = 32'd1 << tile_reg_id_i;
    end else begin
      sb_set_s = 32'd0;
    end
    if (ret_load_s) begin
      sb_clr_s = 32'd1 << ep_returned_reg_id_r_i;
    end else begin
      sb_clr_s = 32'd0;
    end
    sb_next_s = (sb_r & ~sb_clr_s) | sb_set_s;
  end

  // Scoreboard register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sb_r <= 32'd0;
    end else begin
      sb_r <= sb_next_s;
    end
  end

`ifdef BRG_HCC_REQ_GATE_STATS_EN
  logic [31:0] stall_hazard_cnt_r;
  logic [31:0] stall_credit_cnt_r;

  // Saturating stall counters for hazard holds and credit starvation
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_hazard_cnt_r <= 32'd0;
      stall_credit_cnt_r <= 32'd0;
    end else begin
      if (tile_v_i && hazard_s && (stall_hazard_cnt_r != 32'hFFFF_FFFF)) begin
        stall_hazard_cnt_r <= stall_hazard_cnt_r + 32'd1;
      end
      if (!fifo_empty_s && !credit_ok_s && (stall_credit_cnt_r != 32'hFFFF_FFFF)) begin
        stall_credit_cnt_r <= stall_credit_cnt_r + 32'd1;
      end
    end
  end

  assign stall_hazard_cnt_o = stall_hazard_cnt_r;
  assign stall_credit_cnt_o = stall_credit_cnt_r;
`endif

endmodule

// File: tb/tb_brg_hcc_req_gate.sv
// Directed testbench for brg_hcc_req_gate (default build, credit reserve of 2).
module tb_brg_hcc_req_gate;

  localparam int PW = 8;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          tile_v_i;
  logic [PW-1:0] tile_packet_i;
  logic          tile_is_load_i;
  logic [4:0]    tile_reg_id_i;
  logic          tile_ready_o;
  logic          ep_v_o;
  logic [PW-1:0] ep_packet_o;
  logic          ep_credit_or_ready_i;
  logic [7:0]    ep_credits_i;
  logic          ep_returned_v_r_i;
  logic [DW-1:0] ep_returned_data_r_i;
  logic [4:0]    ep_returned_reg_id_r_i;
  logic [1:0]    ep_returned_pkt_type_r_i;
  logic          ep_returned_yumi_o;
  logic          tile_returned_v_o;
  logic [DW-1:0] tile_returned_data_o;
  logic [4:0]    tile_returned_reg_id_o;
  logic [1:0]    tile_returned_pkt_type_o;
  logic          tile_returned_yumi_i;

  int total = 0;
  int bad   = 0;

  brg_hcc_req_gate #(
    .packet_width_lp(PW), .data_width_p(DW), .max_out_credits_p(200),
    .credit_reserve_p(2), .load_ret_type_p(2'b00)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .tile_v_i(tile_v_i), .tile_packet_i(tile_packet_i),
    .tile_is_load_i(tile_is_load_i), .tile_reg_id_i(tile_reg_id_i),
    .tile_ready_o(tile_ready_o),
    .ep_v_o(ep_v_o), .ep_packet_o(ep_packet_o),
    .ep_credit_or_ready_i(ep_credit_or_ready_i), .ep_credits_i(ep_credits_i),
    .ep_returned_v_r_i(ep_returned_v_r_i), .ep_returned_data_r_i(ep_returned_data_r_i),
    .ep_returned_reg_id_r_i(ep_returned_reg_id_r_i),
    .ep_returned_pkt_type_r_i(ep_returned_pkt_type_r_i),
    .ep_returned_yumi_o(ep_returned_yumi_o),
    .tile_returned_v_o(tile_returned_v_o), .tile_returned_data_o(tile_returned_data_o),
    .tile_returned_reg_id_o(tile_returned_reg_id_o),
    .tile_returned_pkt_type_o(tile_returned_pkt_type_o),
    .tile_returned_yumi_i(tile_returned_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive_req(input logic v, input logic [PW-1:0] pkt, input logic ld, input logic [4:0] rid);
    tile_v_i = v; tile_packet_i = pkt; tile_is_load_i = ld; tile_reg_id_i = rid;
  endtask

  task automatic drive_resp(input logic v, input logic [1:0] typ, input logic [4:0] rid, input logic [DW-1:0] d);
    ep_returned_v_r_i = v; ep_returned_pkt_type_r_i = typ; ep_returned_reg_id_r_i = rid;
    ep_returned_data_r_i = d; tile_returned_yumi_i = v;
  endtask

  // Each step: move to negedge, apply inputs, settle 1 time unit, then check.
  task automatic test_reset();
    reset_n_i = 1'b0; drive_req(1'b0, 8'h00, 1'b0, 5'd0); drive_resp(1'b0, 2'b00, 5'd0, 32'd0);
    ep_credit_or_ready_i = 1'b1; ep_credits_i = 8'd200;
    #1;
    total++; if (ep_v_o !== 1'b0) begin $display("FAIL rst_ep_v got=%0b exp=0", ep_v_o); bad++; end
    total++; if (tile_ready_o !== 1'b1) begin $display("FAIL rst_ready got=%0b exp=1", tile_ready_o); bad++; end
    total++; if (dut.sb_r !== 32'd0) begin $display("FAIL rst_sb got=%0h exp=0", dut.sb_r); bad++; end
    @(negedge clk_i); reset_n_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i); drive_req(1'b1, 8'hA1, 1'b0, 5'd3); #1;
    total++; if (tile_ready_o !== 1'b1 || ep_v_o !== 1'b0) begin $display("FAIL b2b_c0 got ready=%0b v=%0b exp ready=1 v=0", tile_ready_o, ep_v_o); bad++; end
    @(negedge clk_i); drive_req(1'b1, 8'hB2, 1'b0, 5'd4); #1;
    total++; if (tile_ready_o !== 1'b1 || ep_v_o !== 1'b1 || ep_packet_o !== 8'hA1) begin $display("FAIL b2b_c1 got ready=%0b v=%0b pkt=%0h exp 1 1 a1", tile_ready_o, ep_v_o, ep_packet_o); bad++; end
    @(negedge clk_i); drive_req(1'b0, 8'h00, 1'b0, 5'd0); #1;
    total++; if (ep_v_o !== 1'b1 || ep_packet_o !== 8'hB2) begin $display("FAIL b2b_c2 got v=%0b pkt=%0h exp 1 b2", ep_v_o, ep_packet_o); bad++; end
    @(negedge clk_i); #1;
    total++; if (ep_v_o !== 1'b0 || dut.sb_r !== 32'd0) begin $display("FAIL b2b_c3 got v=%0b sb=%0h exp 0 0", ep_v_o, dut.sb_r); bad++; end
  endtask

  task automatic test_backpressure();
    @(negedge clk_i); ep_credit_or_ready_i = 1'b0; drive_req(1'b1, 8'hC1, 1'b0, 5'd0); #1;
    total++; if (tile_ready_o !== 1'b1) begin $display("FAIL bp_a_ready got=%0b exp=1", tile_ready_o); bad++; end
    @(negedge clk_i); drive_req(1'b1, 8'hC2, 1'b0, 5'd0); #1;
    total++; if (tile_ready_o !== 1'b1 || ep_packet_o !== 8'hC1) begin $display("FAIL bp_b got ready=%0b pkt=%0h exp 1 c1", tile_ready_o, ep_packet_o); bad++; end
    @(negedge clk_i); drive_req(1'b1, 8'hC3, 1'b0, 5'd0); #1;
    total++; if (tile_ready_o !== 1'b0 || ep_v_o !== 1'b1 || ep_packet_o !== 8'hC1) begin $display("FAIL bp_full got ready=%0b v=%0b pkt=%0h exp 0 1 c1", tile_ready_o, ep_v_o, ep_packet_o); bad++; end
    @(negedge clk_i); ep_credit_or_ready_i = 1'b1; #1;
    total++; if (tile_ready_o !== 1'b0 || ep_packet_o !== 8'hC1) begin $display("FAIL bp_rel got ready=%0b pkt=%0h exp 0 c1", tile_ready_o, ep_packet_o); bad++; end
    @(negedge clk_i); #1;
    total++; if (tile_ready_o !== 1'b1 || ep_packet_o !== 8'hC2) begin $display("FAIL bp_b_out got ready=%0b pkt=%0h exp 1 c2", tile_ready_o, ep_packet_o); bad++; end
    @(negedge clk_i); drive_req(1'b0, 8'h00, 1'b0, 5'd0); #1;
    total++; if (ep_v_o !== 1'b1 || ep_packet_o !== 8'hC3) begin $display("FAIL bp_c_out got v=%0b pkt=%0h exp 1 c3", ep_v_o, ep_packet_o); bad++; end
    @(negedge clk_i); #1;
    total++; if (ep_v_o !== 1'b0) begin $display("FAIL bp_drain got=%0b exp=0", ep_v_o); bad++; end
  endtask

  task automatic test_waw_hazard();
    @(negedge clk_i); drive_req(1'b1, 8'h51, 1'b1, 5'd5); #1;
    total++; if (tile_ready_o !== 1'b1) begin $display("FAIL waw_first got=%0b exp=1", tile_ready_o); bad++; end
    @(negedge clk_i); drive_req(1'b1, 8'h52, 1'b1, 5'd5); #1;
    total++; if (tile_ready_o !== 1'b0 || dut.sb_r !== 32'h0000_0020) begin $display("FAIL waw_stall got ready=%0b sb=%0h exp 0 20", tile_ready_o, dut.sb_r); bad++; end
    @(negedge clk_i); drive_resp(1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF); #1;
    total++; if (tile_ready_o !== 1'b0) begin $display("FAIL waw_clr_cycle got=%0b exp=0", tile_ready_o); bad++; end
    total++; if (tile_returned_v_o !== 1'b1 || tile_returned_data_o !== 32'hDEAD_BEEF || tile_returned_reg_id_o !== 5'd5 || ep_returned_yumi_o !== 1'b1) begin
      $display("FAIL resp_pass got v=%0b d=%0h r=%0d y=%0b exp 1 deadbeef 5 1", tile_returned_v_o, tile_returned_data_o, tile_returned_reg_id_o, ep_returned_yumi_o); bad++; end
    @(negedge clk_i); drive_resp(1'b0, 2'b00, 5'd0, 32'd0); #1;
    total++; if (tile_ready_o !== 1'b1 || dut.sb_r !== 32'd0) begin $display("FAIL waw_after got ready=%0b sb=%0h exp 1 0", tile_ready_o, dut.sb_r); bad++; end
    @(negedge clk_i); drive_req(1'b0, 8'h00, 1'b0, 5'd0); drive_resp(1'b1, 2'b01, 5'd5, 32'h1); #1;
    total++; if (dut.sb_r !== 32'h0000_0020 || tile_returned_pkt_type_o !== 2'b01) begin $display("FAIL waw_reset got sb=%0h typ=%0d exp 20 1", dut.sb_r, tile_returned_pkt_type_o); bad++; end
    @(negedge clk_i); drive_req(1'b1, 8'h90, 1'b1, 5'd9); drive_resp(1'b1, 2'b00, 5'd5, 32'h2); #1;
    total++; if (dut.sb_r !== 32'h0000_0020 || tile_ready_o !== 1'b1) begin $display("FAIL nonload_resp got sb=%0h ready=%0b exp 20 1", dut.sb_r, tile_ready_o); bad++; end
    @(negedge clk_i); drive_req(1'b0, 8'h00, 1'b0, 5'd0); drive_resp(1'b1, 2'b00, 5'd9, 32'h3); #1;
    total++; if (dut.sb_r !== 32'h0000_0200) begin $display("FAIL set_clr_same got sb=%0h exp 200", dut.sb_r); bad++; end
    @(negedge clk_i); drive_resp(1'b0, 2'b00, 5'd0, 32'd0); #1;
    total++; if (dut.sb_r !== 32'd0) begin $display("FAIL sb_clean got sb=%0h exp 0", dut.sb_r); bad++; end
  endtask

  task automatic test_load_x0();
    @(negedge clk_i); drive_req(1'b1, 8'h01, 1'b1, 5'd0); #1;
    total++; if (tile_ready_o !== 1'b1) begin $display("FAIL x0_first got=%0b exp=1", tile_ready_o); bad++; end
    @(negedge clk_i); drive_req(1'b1, 8'h02, 1'b1, 5'd0); #1;
    total++; if (tile_ready_o !== 1'b1 || dut.sb_r !== 32'd0) begin $display("FAIL x0_second got ready=%0b sb=%0h exp 1 0", tile_ready_o, dut.sb_r); bad++; end
    @(negedge clk_i); drive_req(1'b0, 8'h00, 1'b0, 5'd0); #1;
    total++; if (dut.sb_r !== 32'd0) begin $display("FAIL x0_sb got=%0h exp 0", dut.sb_r); bad++; end
    @(negedge clk_i); @(negedge clk_i);
  endtask

  task automatic test_credit_reserve();
    @(negedge clk_i); ep_credit_or_ready_i = 1'b0; ep_credits_i = 8'd2; drive_req(1'b1, 8'h77, 1'b0, 5'd0); #1;
    @(negedge clk_i); drive_req(1'b0, 8'h00, 1'b0, 5'd0); #1;
    total++; if (ep_v_o !== 1'b0) begin $display("FAIL cr_at_reserve got=%0b exp=0", ep_v_o); bad++; end
    ep_credits_i = 8'd3; #1;
    total++; if (ep_v_o !== 1'b1 || ep_packet_o !== 8'h77) begin $display("FAIL cr_above got v=%0b pkt=%0h exp 1 77", ep_v_o, ep_packet_o); bad++; end
    @(negedge clk_i); ep_credit_or_ready_i = 1'b1; ep_credits_i = 8'd200;
    @(negedge clk_i); #1;
    total++; if (ep_v_o !== 1'b0) begin $display("FAIL cr_drain got=%0b exp=0", ep_v_o); bad++; end
  endtask

  task automatic test_mid_reset();
    @(negedge clk_i); ep_credit_or_ready_i = 1'b0; drive_req(1'b1, 8'h71, 1'b1, 5'd7);
    @(negedge clk_i); drive_req(1'b1, 8'h72, 1'b0, 5'd0);
    @(negedge clk_i); drive_req(1'b0, 8'h00, 1'b0, 5'd0); #1;
    total++; if (ep_v_o !== 1'b1 || dut.sb_r !== 32'h0000_0080 || tile_ready_o !== 1'b0) begin $display("FAIL mr_pre got v=%0b sb=%0h ready=%0b exp 1 80 0", ep_v_o, dut.sb_r, tile_ready_o); bad++; end
    #1 reset_n_i = 1'b0; #1;
    total++; if (ep_v_o !== 1'b0 || dut.sb_r !== 32'd0 || tile_ready_o !== 1'b1) begin $display("FAIL mr_in got v=%0b sb=%0h ready=%0b exp 0 0 1", ep_v_o, dut.sb_r, tile_ready_o); bad++; end
    @(negedge clk_i); reset_n_i = 1'b1; drive_req(1'b1, 8'h73, 1'b1, 5'd7); #1;
    total++; if (tile_ready_o !== 1'b1 || ep_v_o !== 1'b0) begin $display("FAIL mr_post got ready=%0b v=%0b exp 1 0", tile_ready_o, ep_v_o); bad++; end
    @(negedge clk_i); drive_req(1'b0, 8'h00, 1'b0, 5'd0); #1;
    total++; if (dut.sb_r !== 32'h0000_0080 || ep_v_o !== 1'b1 || ep_packet_o !== 8'h73) begin $display("FAIL mr_load got sb=%0h v=%0b pkt=%0h exp 80 1 73", dut.sb_r, ep_v_o, ep_packet_o); bad++; end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_waw_hazard();
    test_load_x0();
    test_credit_reserve();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
